// File: rtl/regfile_param_if.sv
// regfile_param_if: read, write and dump-handshake signals of the register file
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              RegWrite;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport slave (
        input  read_reg1, read_reg2, RegWrite, write_reg, write_data, dump_start, dump_ready,
        output read_data1, read_data2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

    modport master (
        output read_reg1, read_reg2, RegWrite, write_reg, write_data, dump_start, dump_ready,
        input  read_data1, read_data2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R/1W register file with handshaked dump port; REGFILE_BYPASS_EN enables write-first forwarding
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input logic           clk,
    input logic           rst,
    regfile_param_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SHOW = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [ADDR_W:0]   NUM  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q;
    logic              wr_ok;

    // an address is live if implemented and not the hardwired zero register
    function automatic logic ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM) && !(ZERO_REG != 0 && a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return ok(a) ? regs[a] : '0;
    endfunction

    assign wr_ok = bus.RegWrite && ok(bus.write_reg);

    // read ports, optionally forwarding the write in flight
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        bus.read_data1 = (wr_ok && bus.write_reg == bus.read_reg1) ? bus.write_data : rd(bus.read_reg1);
        bus.read_data2 = (wr_ok && bus.write_reg == bus.read_reg2) ? bus.write_data : rd(bus.read_reg2);
`else
        bus.read_data1 = rd(bus.read_reg1);
        bus.read_data2 = rd(bus.read_reg2);
`endif
    end

    // register array: clear on reset, otherwise accept legal writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    // dump FSM: capture one register per LOAD, present it in SHOW until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.dump_start) begin
                    idx   <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    dump_data_q <= rd(idx);
                    dump_addr_q <= idx;
                    state       <= SHOW;
                end
                SHOW: if (bus.dump_ready) begin
                    if (idx == LAST) state <= DONE;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dump_busy  = state != IDLE;
    assign bus.dump_valid = state == SHOW;
    assign bus.dump_done  = state == DONE;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: vector table for read/write, scoreboard-checked dump sequences
module tb_regfile_param;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_pass = 0;
    int    n_tot = 0;
    beat_t q[$];
    vec_t  vt[8];

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bz ();

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(20), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst(rst), .bus(bz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        bus.RegWrite = 1'b1;
        bus.write_reg = a;
        bus.write_data = d;
        tick();
        bus.RegWrite = 1'b0;
    endtask

    task automatic sweep_zero(input string n);
        for (int i = 0; i < 32; i++) begin
            bus.read_reg1 = 5'(i);
            bus.read_reg2 = 5'(31 - i);
            #1;
            check(n, bus.read_data1, 32'h0);
        end
    endtask

    task automatic run_dump(input int mode, input bit collide);
        int    cyc = 0;
        int    done_cnt = 0;
        int    done_cyc = -1;
        bit    stall = 1'b0;
        bit    wr = 1'b0;
        beat_t e;
        logic [4:0]  ha = '0;
        logic [31:0] hd = '0;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        while (done_cnt == 0 && cyc < 400) begin
            bus.dump_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            bus.RegWrite = wr;
            bus.write_reg = 5'd3;
            bus.write_data = 32'hAAAA0000;
            wr = 1'b0;
            #1;
            if (stall && bus.dump_valid) begin
                check("stall_addr", {27'd0, bus.dump_addr}, {27'd0, ha});
                check("stall_data", bus.dump_data, hd);
            end
            if (bus.dump_valid && bus.dump_ready) begin
                if (q.size() == 0) check("extra_beat", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("beat_addr", {27'd0, bus.dump_addr}, {27'd0, e.a});
                    check("beat_data", bus.dump_data, e.d);
                end
                if (collide && bus.dump_addr == 5'd2) wr = 1'b1;
            end
            stall = bus.dump_valid && !bus.dump_ready;
            ha = bus.dump_addr;
            hd = bus.dump_data;
            if (bus.dump_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            tick();
            cyc++;
        end
        bus.RegWrite = 1'b0;
        check("done_count", done_cnt, 1);
        check("beats_left", q.size(), 0);
        if (mode == 0) check("dump_cycles", done_cyc, 64);
        check("busy_after", {31'd0, bus.dump_busy}, 32'd0);
        check("done_after", {31'd0, bus.dump_done}, 32'd0);
    endtask

    task automatic push_all(input bit zeros, input bit collide);
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.a = 5'(i);
            b.d = (zeros || i == 0) ? 32'h0 : 32'h100 + 32'(i);
            q.push_back(b);
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd5,  32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0, 32'h0};
        vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
        vt[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, BYP ? 32'hFFFFFFFF : 32'h0, 32'h0};
        vt[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF};
        vt[6] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, BYP ? 32'h1 : 32'hDEADBEEF, 32'hFFFFFFFF};
        vt[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h1, 32'h0};

        bus.read_reg1 = '0; bus.read_reg2 = '0; bus.RegWrite = 1'b0; bus.write_reg = '0;
        bus.write_data = '0; bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
        bz.read_reg1 = '0; bz.read_reg2 = '0; bz.RegWrite = 1'b0; bz.write_reg = '0;
        bz.write_data = '0; bz.dump_start = 1'b0; bz.dump_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy",  {31'd0, bus.dump_busy},  32'd0);
        check("rst_valid", {31'd0, bus.dump_valid}, 32'd0);
        check("rst_done",  {31'd0, bus.dump_done},  32'd0);
        check("rst_daddr", {27'd0, bus.dump_addr},  32'd0);
        check("rst_ddata", bus.dump_data, 32'd0);
        sweep_zero("rst_read");

        for (int i = 0; i < 8; i++) begin
            bus.RegWrite = vt[i].we;
            bus.write_reg = vt[i].wa;
            bus.write_data = vt[i].wd;
            bus.read_reg1 = vt[i].ra1;
            bus.read_reg2 = vt[i].ra2;
            #1;
            check($sformatf("vec%0d_rd1", i), bus.read_data1, vt[i].e1);
            check($sformatf("vec%0d_rd2", i), bus.read_data2, vt[i].e2);
            tick();
        end
        bus.RegWrite = 1'b0;

        bz.RegWrite = 1'b1; bz.write_reg = 5'd0;  bz.write_data = 32'h12345678; tick();
        bz.write_reg = 5'd25; bz.write_data = 32'h55; tick();
        bz.write_reg = 5'd19; bz.write_data = 32'h77; tick();
        bz.RegWrite = 1'b0;
        bz.read_reg1 = 5'd0; bz.read_reg2 = 5'd25; #1;
        check("z0_reg0", bz.read_data1, 32'h12345678);
        check("z0_oor",  bz.read_data2, 32'h0);
        bz.read_reg1 = 5'd19; #1;
        check("z0_last", bz.read_data1, 32'h77);

        write(5'd0, 32'h12345678);
        for (int i = 1; i < 32; i++) write(5'(i), 32'h100 + 32'(i));
        bus.read_reg1 = 5'd0; #1;
        check("zero_reg", bus.read_data1, 32'h0);

        push_all(1'b0, 1'b0);
        run_dump(1, 1'b0);

        push_all(1'b0, 1'b1);
        run_dump(0, 1'b1);
        bus.read_reg1 = 5'd3; #1;
        check("collide_rd", bus.read_data1, 32'hAAAA0000);

        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        for (int c = 0; c < 100 && !(bus.dump_valid && bus.dump_addr == 5'd10); c++) tick();
        check("mid_addr", {27'd0, bus.dump_addr}, 32'd10);
        bus.dump_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'd0, bus.dump_valid}, 32'd0);
        check("mid_busy",  {31'd0, bus.dump_busy},  32'd0);
        check("mid_done",  {31'd0, bus.dump_done},  32'd0);
        tick();
        check("mid_done2", {31'd0, bus.dump_done},  32'd0);
        sweep_zero("mid_read");

        push_all(1'b1, 1'b0);
        run_dump(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
